// File: rtl/if_pc_unit.sv
// Instruction-fetch PC unit: sequential fetch, branch/jump redirect with a
// hold register for redirects that arrive while instruction memory is busy,
// stall handling, flush generation and a sticky misaligned-target flag.
module if_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] BRANCH_JUMP_TARGET,
    input  logic        BRANCH_JUMP_TAKEN,
    input  logic        STALL,
    input  logic        IMEM_BUSY,
    output logic [31:0] PC_OUT,
    output logic [31:0] IF_ID_PC,
    output logic        IF_ID_VALID,
    output logic        FLUSH,
    output logic        MISALIGN_ERR
);

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] MEM_WAIT   = 2'd1;
    localparam logic [1:0] REDIR_WAIT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] hold_q, hold_d;
    logic        misalign_q, misalign_d;
    logic [31:0] target_aligned;
    logic [31:0] redir_pc;

    assign target_aligned = BRANCH_JUMP_TARGET & ~32'h3;
    // In REDIR_WAIT a fresh redirect supersedes the captured one.
    assign redir_pc       = BRANCH_JUMP_TAKEN ? target_aligned : hold_q;

    // Next-state selection: redirect, then stall, then busy, then advance.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned, which would infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        hold_d        = hold_q;
        misalign_d    = misalign_q |
                        (BRANCH_JUMP_TAKEN && (BRANCH_JUMP_TARGET[1:0] != 2'b00));

        if (state_q == REDIR_WAIT) begin
            // Stall is ignored here: the redirect must complete.
            if_id_valid_d = 1'b0;
            if (BRANCH_JUMP_TAKEN) begin
                hold_d = target_aligned;
            end
            if (!IMEM_BUSY) begin
                pc_d    = redir_pc;
                state_d = RUN;
            end
        end else if (BRANCH_JUMP_TAKEN) begin
            if_id_valid_d = 1'b0;
            if (IMEM_BUSY) begin
                hold_d  = target_aligned;
                state_d = REDIR_WAIT;
            end else begin
                pc_d    = target_aligned;
                state_d = RUN;
            end
        end else if (STALL) begin
            // Hold everything.
        end else if (IMEM_BUSY) begin
            if_id_valid_d = 1'b0;
            state_d       = MEM_WAIT;
        end else begin
            if_id_pc_d    = pc_q;
            if_id_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;  // wraps modulo 2^32
            state_d       = RUN;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= RUN;
            pc_q          <= RESET_VECTOR;
            if_id_pc_q    <= 32'h0;
            if_id_valid_q <= 1'b0;
            hold_q        <= 32'h0;
            misalign_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
            hold_q        <= hold_d;
            misalign_q    <= misalign_d;
        end
    end

    assign PC_OUT       = pc_q;
    assign IF_ID_PC     = if_id_pc_q;
    assign IF_ID_VALID  = if_id_valid_q;
    assign MISALIGN_ERR = misalign_q;
    assign FLUSH        = BRANCH_JUMP_TAKEN || (state_q == REDIR_WAIT);

endmodule
